// File: rtl/io_sched.sv
// io_sched: two-requester scheduler in front of the PDS bus sequencer.
//   R0 (CPU side): writes with a strobe set are posted into an in-order
//     queue of WQD entries; reads wait until the queue has drained.
//   R1 (auxiliary): every access is blocking and bypasses the queue.
//   The two candidates are arbitrated round-robin. The winner is latched
//   into the IO* attribute outputs, and IOREQ is held until IODONE.
// Ports:
//   C16M, RES                     clock, async active-high reset
//   R0*/R1* REQ RW A LDS UDS WD   requester inputs (level, held to ACK)
//   R0ACK/R1ACK, R0RD/R1RD        one-cycle completion pulse, read data
//   IOREQ IORW IOLDS IOUDS IOA IOWD   request and attributes to sequencer
//   IORD IOACT IODONE             read data, busy and done from sequencer
//   WQFULL WQEMPTY BUSY           queue and FSM status
module io_sched #(
  parameter int AW  = 23,
  parameter int DW  = 16,
  parameter int WQD = 2
) (
  input  logic          C16M,
  input  logic          RES,
  input  logic          R0REQ,
  input  logic          R0RW,
  input  logic [AW-1:0] R0A,
  input  logic          R0LDS,
  input  logic          R0UDS,
  input  logic [DW-1:0] R0WD,
  output logic          R0ACK,
  output logic [DW-1:0] R0RD,
  input  logic          R1REQ,
  input  logic          R1RW,
  input  logic [AW-1:0] R1A,
  input  logic          R1LDS,
  input  logic          R1UDS,
  input  logic [DW-1:0] R1WD,
  output logic          R1ACK,
  output logic [DW-1:0] R1RD,
  output logic          IOREQ,
  output logic          IORW,
  output logic          IOLDS,
  output logic          IOUDS,
  output logic [AW-1:0] IOA,
  output logic [DW-1:0] IOWD,
  input  logic [DW-1:0] IORD,
  input  logic          IOACT,
  input  logic          IODONE,
  output logic          WQFULL,
  output logic          WQEMPTY,
  output logic          BUSY
);

  localparam int PW = $clog2(WQD);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RELEASE = 2'd2} state_t;
  localparam logic [1:0] SRC_Q  = 2'd0;
  localparam logic [1:0] SRC_R0 = 2'd1;
  localparam logic [1:0] SRC_R1 = 2'd2;

  state_t state_r, state_s;

  // Queue pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0]    wr_ptr_r, rd_ptr_r;
  logic [AW-1:0]  qa_r  [WQD];
  logic [DW-1:0]  qwd_r [WQD];
  logic [WQD-1:0] qlds_r, quds_r;

  logic [1:0]    src_r;
  logic          rr_ptr_r;
  logic          ioreq_r, iorw_r, iolds_r, iouds_r;
  logic [AW-1:0] ioa_r;
  logic [DW-1:0] iowd_r;
  logic          r0ack_r, r1ack_r;
  logic [DW-1:0] r0rd_r, r1rd_r;

  logic          wqempty_s, wqfull_s, push_s, nostrobe_s, r0rd_elig_s;
  logic          c0_s, c1_s, bus_idle_s, pick0_s;
  logic          grant_s, done_s, pop_s, ack0_s, ack1_s;
  logic [1:0]    sel_src_s;
  logic          sel_rw_s, sel_lds_s, sel_uds_s;
  logic [AW-1:0] sel_a_s;
  logic [DW-1:0] sel_wd_s;

  assign wqempty_s = (wr_ptr_r == rd_ptr_r);
  assign wqfull_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                     (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);

  // While an ACK is high the requester still shows the request just served,
  // so nothing from that requester is taken in that cycle.
  assign push_s      = R0REQ && !R0RW && (R0LDS || R0UDS) && !wqfull_s && !r0ack_r;
  assign nostrobe_s  = R0REQ && !R0RW && !R0LDS && !R0UDS && !r0ack_r;
  // Reads may only go out once every posted write has completed on the bus.
  assign r0rd_elig_s = R0REQ && R0RW && wqempty_s && !r0ack_r;

  assign c0_s       = !wqempty_s || r0rd_elig_s;
  assign c1_s       = R1REQ && !r1ack_r;
  assign bus_idle_s = !IOACT && !IODONE;
  assign pick0_s    = c0_s && (!c1_s || !rr_ptr_r);

  // Winner selection: queue head has priority over an R0 read within C0.
  always_comb begin
    sel_src_s = SRC_R1;
    sel_rw_s  = R1RW;
    sel_a_s   = R1A;
    sel_wd_s  = R1WD;
    sel_lds_s = R1LDS;
    sel_uds_s = R1UDS;
    if (pick0_s) begin
      if (!wqempty_s) begin
        sel_src_s = SRC_Q;
        sel_rw_s  = 1'b0;
        sel_a_s   = qa_r[rd_ptr_r[PW-1:0]];
        sel_wd_s  = qwd_r[rd_ptr_r[PW-1:0]];
        sel_lds_s = qlds_r[rd_ptr_r[PW-1:0]];
        sel_uds_s = quds_r[rd_ptr_r[PW-1:0]];
      end else begin
        sel_src_s = SRC_R0;
        sel_rw_s  = 1'b1;
        sel_a_s   = R0A;
        sel_wd_s  = R0WD;
        sel_lds_s = R0LDS;
        sel_uds_s = R0UDS;
      end
    end else begin
      sel_src_s = SRC_R1;
      sel_rw_s  = R1RW;
      sel_a_s   = R1A;
      sel_wd_s  = R1WD;
      sel_lds_s = R1LDS;
      sel_uds_s = R1UDS;
    end
  end

  // FSM state register.
  always_ff @(posedge C16M or posedge RES) begin
    if (RES) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:    state_s = (bus_idle_s && (c0_s || c1_s)) ? S_ISSUE : S_IDLE;
      S_ISSUE:   state_s = IODONE ? S_RELEASE : S_ISSUE;
      S_RELEASE: state_s = bus_idle_s ? S_IDLE : S_RELEASE;
      default:   state_s = S_IDLE;
    endcase
  end

  // FSM output strobes; IODONE outside ISSUE produces nothing.
  always_comb begin
    grant_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE:  grant_s = bus_idle_s && (c0_s || c1_s);
      S_ISSUE: done_s  = IODONE;
      default: begin
        grant_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  assign pop_s  = done_s && (src_r == SRC_Q);
  assign ack0_s = done_s && (src_r == SRC_R0);
  assign ack1_s = done_s && (src_r == SRC_R1);

  // Posted-write queue storage and pointers (fullness sampled before pop).
  always_ff @(posedge C16M or posedge RES) begin
    if (RES) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
      qlds_r   <= {WQD{1'b0}};
      quds_r   <= {WQD{1'b0}};
      for (int i = 0; i < WQD; i++) begin
        qa_r[i]  <= {AW{1'b0}};
        qwd_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (push_s) begin
        qa_r[wr_ptr_r[PW-1:0]]   <= R0A;
        qwd_r[wr_ptr_r[PW-1:0]]  <= R0WD;
        qlds_r[wr_ptr_r[PW-1:0]] <= R0LDS;
        quds_r[wr_ptr_r[PW-1:0]] <= R0UDS;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Bus attribute latch, IOREQ and round-robin pointer (loser goes next).
  always_ff @(posedge C16M or posedge RES) begin
    if (RES) begin
      ioreq_r  <= 1'b0;
      iorw_r   <= 1'b1;
      iolds_r  <= 1'b0;
      iouds_r  <= 1'b0;
      ioa_r    <= {AW{1'b0}};
      iowd_r   <= {DW{1'b0}};
      src_r    <= SRC_Q;
      rr_ptr_r <= 1'b0;
    end else if (grant_s) begin
      ioreq_r  <= 1'b1;
      iorw_r   <= sel_rw_s;
      iolds_r  <= sel_lds_s;
      iouds_r  <= sel_uds_s;
      ioa_r    <= sel_a_s;
      iowd_r   <= sel_wd_s;
      src_r    <= sel_src_s;
      rr_ptr_r <= pick0_s;
    end else if (done_s) begin
      ioreq_r  <= 1'b0;
    end
  end

  // Completion pulses and read-data capture.
  always_ff @(posedge C16M or posedge RES) begin
    if (RES) begin
      r0ack_r <= 1'b0;
      r1ack_r <= 1'b0;
      r0rd_r  <= {DW{1'b0}};
      r1rd_r  <= {DW{1'b0}};
    end else begin
      r0ack_r <= push_s || nostrobe_s || ack0_s;
      r1ack_r <= ack1_s;
      if (ack0_s && iorw_r) r0rd_r <= IORD;
      if (ack1_s && iorw_r) r1rd_r <= IORD;
    end
  end

  assign IOREQ   = ioreq_r;
  assign IORW    = iorw_r;
  assign IOLDS   = iolds_r;
  assign IOUDS   = iouds_r;
  assign IOA     = ioa_r;
  assign IOWD    = iowd_r;
  assign R0ACK   = r0ack_r;
  assign R1ACK   = r1ack_r;
  assign R0RD    = r0rd_r;
  assign R1RD    = r1rd_r;
  assign WQEMPTY = wqempty_s;
  assign WQFULL  = wqfull_s;
  assign BUSY    = (state_r != S_IDLE);

endmodule

// File: tb/tb_io_sched.sv
// Self-checking bench for io_sched: a behavioural bus sequencer, requester
// tasks, and a monitor that checks bus transfers and ACKs against queues of
// expected results filled by the directed tests.
module tb_io_sched;
  localparam int AW = 23;
  localparam int DW = 16;

  logic          C16M = 1'b0;
  logic          RES;
  logic          R0REQ, R0RW, R0LDS, R0UDS, R0ACK;
  logic [AW-1:0] R0A;
  logic [DW-1:0] R0WD, R0RD;
  logic          R1REQ, R1RW, R1LDS, R1UDS, R1ACK;
  logic [AW-1:0] R1A;
  logic [DW-1:0] R1WD, R1RD;
  logic          IOREQ, IORW, IOLDS, IOUDS, IOACT, IODONE;
  logic [AW-1:0] IOA;
  logic [DW-1:0] IOWD, IORD;
  logic          WQFULL, WQEMPTY, BUSY;

  logic seq_manual, man_act, seq_act, seq_done;
  int   done_hold, sst, scnt;

  assign IOACT  = seq_manual ? man_act : seq_act;
  assign IODONE = seq_manual ? 1'b0    : seq_done;

  always #5 C16M = ~C16M;

  io_sched #(.AW(AW), .DW(DW), .WQD(2)) dut (
    .C16M(C16M), .RES(RES),
    .R0REQ(R0REQ), .R0RW(R0RW), .R0A(R0A), .R0LDS(R0LDS), .R0UDS(R0UDS),
    .R0WD(R0WD), .R0ACK(R0ACK), .R0RD(R0RD),
    .R1REQ(R1REQ), .R1RW(R1RW), .R1A(R1A), .R1LDS(R1LDS), .R1UDS(R1UDS),
    .R1WD(R1WD), .R1ACK(R1ACK), .R1RD(R1RD),
    .IOREQ(IOREQ), .IORW(IORW), .IOLDS(IOLDS), .IOUDS(IOUDS), .IOA(IOA),
    .IOWD(IOWD), .IORD(IORD), .IOACT(IOACT), .IODONE(IODONE),
    .WQFULL(WQFULL), .WQEMPTY(WQEMPTY), .BUSY(BUSY)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [AW-1:0] a; logic rw; logic [DW-1:0] wd; } bus_t;
  typedef struct { logic rd; logic [DW-1:0] data; } ack_t;
  bus_t exp_bus[$];
  ack_t exp_r0[$];
  ack_t exp_r1[$];
  bus_t mb;
  ack_t ma;
  int   r0_acks = 0, r1_acks = 0;

  // Read data the sequencer returns for a given address.
  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return (a == 23'h000200) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  function automatic bus_t mk(input logic [31:0] a, input logic rw, input logic [DW-1:0] wd);
    bus_t b;
    b.a = a[AW-1:0]; b.rw = rw; b.wd = wd;
    return b;
  endfunction

  // Sequencer model: ACT one cycle after IOREQ, DONE two cycles later,
  // DONE/ACT released done_hold cycles after IOREQ falls.
  initial begin
    seq_act = 1'b0; seq_done = 1'b0; IORD = 16'h0000; sst = 0; scnt = 0;
    forever begin
      @(posedge C16M); #2;
      if (seq_manual || RES) begin
        seq_act = 1'b0; seq_done = 1'b0; sst = 0;
      end else begin
        case (sst)
          0: if (IOREQ) begin seq_act = 1'b1; scnt = 0; sst = 1; end
          1: begin
            scnt++;
            if (scnt >= 2) begin seq_done = 1'b1; IORD = rd_of(IOA); sst = 2; scnt = 0; end
          end
          2: if (!IOREQ) begin
            scnt++;
            if (scnt >= done_hold) begin seq_done = 1'b0; seq_act = 1'b0; sst = 0; end
          end
          default: sst = 0;
        endcase
      end
    end
  end

  // Monitor: bus transfers in expected order, legal request gap, ACK data.
  logic ioreq_q = 1'b0, prev_act = 1'b0, prev_done = 1'b0;
  always @(negedge C16M) begin
    if (IOREQ && !ioreq_q) begin
      chk("gap_ioact_iodone", {prev_act, prev_done}, 32'd0);
      if (exp_bus.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_ioreq: transfer at IOA=0x%0h, expected none", IOA);
      end else begin
        mb = exp_bus.pop_front();
        chk("ioa", IOA, mb.a);
        chk("iorw", IORW, mb.rw);
        if (!mb.rw) chk("iowd", IOWD, mb.wd);
      end
    end
    if (R0ACK) begin
      r0_acks++;
      if (exp_r0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_r0ack: R0ACK=1, expected 0");
      end else begin
        ma = exp_r0.pop_front();
        if (ma.rd) chk("r0rd", R0RD, ma.data);
      end
    end
    if (R1ACK) begin
      r1_acks++;
      if (exp_r1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_r1ack: R1ACK=1, expected 0");
      end else begin
        ma = exp_r1.pop_front();
        if (ma.rd) chk("r1rd", R1RD, ma.data);
      end
    end
    ioreq_q   = IOREQ;
    prev_act  = IOACT;
    prev_done = IODONE;
  end

  task automatic r0_op(input logic rw, input logic [31:0] a, input logic [DW-1:0] wd,
                       input logic lds, input logic uds, output int lat);
    ack_t e;
    e.rd = rw; e.data = rd_of(a[AW-1:0]);
    exp_r0.push_back(e);
    @(negedge C16M);
    R0RW = rw; R0A = a[AW-1:0]; R0WD = wd; R0LDS = lds; R0UDS = uds; R0REQ = 1'b1;
    lat = 0;
    while (!R0ACK && lat < 300) begin @(negedge C16M); lat++; end
    if (!R0ACK) begin
      n_vec++; n_err++;
      $display("FAIL r0_ack_timeout: no R0ACK after %0d cycles, expected one", lat);
    end
    R0REQ = 1'b0;
  endtask

  task automatic r1_op(input logic rw, input logic [31:0] a, input logic [DW-1:0] wd, output int lat);
    ack_t e;
    e.rd = rw; e.data = rd_of(a[AW-1:0]);
    exp_r1.push_back(e);
    @(negedge C16M);
    R1RW = rw; R1A = a[AW-1:0]; R1WD = wd; R1LDS = 1'b1; R1UDS = 1'b1; R1REQ = 1'b1;
    lat = 0;
    while (!R1ACK && lat < 300) begin @(negedge C16M); lat++; end
    if (!R1ACK) begin
      n_vec++; n_err++;
      $display("FAIL r1_ack_timeout: no R1ACK after %0d cycles, expected one", lat);
    end
    R1REQ = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge C16M); n++; end
    while (!(WQEMPTY && !BUSY && !IOREQ && !IOACT && !IODONE && sst == 0) && n < 500);
    if (n >= 500) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: scheduler still busy after %0d cycles, expected idle", n);
    end
  endtask

  int lat, lat_a, lat_b, base0, base1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 1'b1; seq_manual = 1'b0; man_act = 1'b0; done_hold = 1;
    R0REQ = 1'b0; R0RW = 1'b1; R0A = '0; R0LDS = 1'b0; R0UDS = 1'b0; R0WD = '0;
    R1REQ = 1'b0; R1RW = 1'b1; R1A = '0; R1LDS = 1'b0; R1UDS = 1'b0; R1WD = '0;
    repeat (3) @(negedge C16M);
    chk("rst_ioreq", IOREQ, 32'd0);
    chk("rst_iorw", IORW, 32'd1);
    chk("rst_iolds", IOLDS, 32'd0);
    chk("rst_iouds", IOUDS, 32'd0);
    chk("rst_ioa", IOA, 32'd0);
    chk("rst_iowd", IOWD, 32'd0);
    chk("rst_r0ack", R0ACK, 32'd0);
    chk("rst_r1ack", R1ACK, 32'd0);
    chk("rst_r0rd", R0RD, 32'd0);
    chk("rst_r1rd", R1RD, 32'd0);
    chk("rst_wqempty", WQEMPTY, 32'd1);
    chk("rst_wqfull", WQFULL, 32'd0);
    chk("rst_busy", BUSY, 32'd0);
    @(negedge C16M); RES = 1'b0;
    @(negedge C16M);

    // Round-robin: first grant R0, then strict alternation.
    for (int i = 0; i < 3; i++) begin
      exp_bus.push_back(mk(32'h400 + i, 1'b1, 16'h0000));
      exp_bus.push_back(mk(32'h500 + i, 1'b1, 16'h0000));
    end
    fork
      begin for (int i = 0; i < 3; i++) r0_op(1'b1, 32'h400 + i, 16'h0000, 1'b1, 1'b1, lat_a); end
      begin for (int j = 0; j < 3; j++) r1_op(1'b1, 32'h500 + j, 16'h0000, lat_b); end
    join
    wait_idle();

    // Posted writes into a 2-deep queue; third write waits for a pop.
    exp_bus.push_back(mk(32'h100, 1'b0, 16'h1111));
    exp_bus.push_back(mk(32'h101, 1'b0, 16'h2222));
    exp_bus.push_back(mk(32'h102, 1'b0, 16'h3333));
    r0_op(1'b0, 32'h100, 16'h1111, 1'b1, 1'b1, lat);
    chk("w1_ack_latency", lat, 32'd1);
    r0_op(1'b0, 32'h101, 16'h2222, 1'b1, 1'b1, lat);
    chk("w2_ack_latency", lat, 32'd1);
    chk("w2_wqfull", WQFULL, 32'd1);
    r0_op(1'b0, 32'h102, 16'h3333, 1'b1, 1'b1, lat);
    chk("w3_ack_delayed", (lat >= 2), 32'd1);
    wait_idle();

    // Read after write to the same address must follow the write on the bus.
    exp_bus.push_back(mk(32'h200, 1'b0, 16'h4444));
    exp_bus.push_back(mk(32'h200, 1'b1, 16'h0000));
    r0_op(1'b0, 32'h200, 16'h4444, 1'b1, 1'b1, lat);
    r0_op(1'b1, 32'h200, 16'h0000, 1'b1, 1'b1, lat);
    chk("raw_r0rd_direct", R0RD, 32'h0000BEEF);
    wait_idle();

    // Write with no strobes: ACK only, nothing queued, no bus transfer.
    r0_op(1'b0, 32'h280, 16'h5555, 1'b0, 1'b0, lat);
    chk("nostrobe_ack_latency", lat, 32'd1);
    chk("nostrobe_wqempty", WQEMPTY, 32'd1);
    repeat (4) @(negedge C16M);
    chk("nostrobe_no_ioreq", IOREQ, 32'd0);

    // Held IODONE: one ACK, one pop, next request only after DONE falls.
    done_hold = 4;
    base0 = r0_acks; base1 = r1_acks;
    exp_bus.push_back(mk(32'h300, 1'b0, 16'h6666));
    exp_bus.push_back(mk(32'h301, 1'b1, 16'h0000));
    fork
      r0_op(1'b0, 32'h300, 16'h6666, 1'b1, 1'b1, lat_a);
      begin repeat (2) @(negedge C16M); r1_op(1'b1, 32'h301, 16'h0000, lat_b); end
    join
    wait_idle();
    chk("held_r0_ack_count", r0_acks - base0, 32'd1);
    chk("held_r1_ack_count", r1_acks - base1, 32'd1);
    chk("held_wqempty", WQEMPTY, 32'd1);
    chk("held_wqfull", WQFULL, 32'd0);
    done_hold = 1;

    // Reset while ISSUE holds a queued write and a second one waits.
    seq_manual = 1'b1; man_act = 1'b0;
    exp_bus.push_back(mk(32'h600, 1'b0, 16'h7777));
    r0_op(1'b0, 32'h600, 16'h7777, 1'b1, 1'b1, lat);
    r0_op(1'b0, 32'h601, 16'h8888, 1'b1, 1'b1, lat);
    @(negedge C16M);
    chk("pre_rst_ioreq", IOREQ, 32'd1);
    chk("pre_rst_wqfull", WQFULL, 32'd1);
    man_act = 1'b1;
    #2 RES = 1'b1;
    #1;
    chk("rst_mid_ioreq", IOREQ, 32'd0);
    chk("rst_mid_wqempty", WQEMPTY, 32'd1);
    chk("rst_mid_busy", BUSY, 32'd0);
    @(negedge C16M); RES = 1'b0;
    exp_bus.push_back(mk(32'h700, 1'b1, 16'h0000));
    fork
      r1_op(1'b1, 32'h700, 16'h0000, lat_b);
      begin
        repeat (5) begin @(negedge C16M); chk("ioact_hold_no_ioreq", IOREQ, 32'd0); end
        man_act = 1'b0; seq_manual = 1'b0;
      end
    join
    wait_idle();
    chk("r1_after_reset_rd", R1RD, 32'h00005A5A ^ 32'h00000700);
    chk("end_bus_queue_empty", exp_bus.size(), 32'd0);
    chk("end_r0_queue_empty", exp_r0.size(), 32'd0);
    chk("end_r1_queue_empty", exp_r1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
